pong_hit_score: RTL

PONG_HIT_SCORE -- requirements
Module: pong_hit_score

---
 rtl/pong_hit_score.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pong_hit_score.sv
// Pong paddle-hit detection and scoring FSM: decides hit vs. miss each cycle in
// PLAY, blanks detection for a lockout window after a hit, and keeps the game score.
`timescale 1ns/1ps
module pong_hit_score #(
  parameter int POS_MAX        = 620,
  parameter int POS_MIN        = 20,
  parameter int PADDLE_L_X     = 30,
  parameter int PADDLE_R_X     = 610,
  parameter int PADDLE_HEIGHT  = 80,
  parameter int WIN_SCORE      = 9,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [10:0] i_Ball_X,
  input  logic [10:0] i_Ball_Y,
  input  logic        i_Direction,
  input  logic [10:0] i_Paddle_L_Y,
  input  logic [10:0] i_Paddle_R_Y,
  input  logic        i_Space,
  output logic        o_Paddle_Hit,
  output logic        o_Win,
  output logic [3:0]  o_Score_L,
  output logic [3:0]  o_Score_R,
  output logic        o_Game_Over,
  output logic        o_Winner
);

  localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [11:0] MAX_X = 12'(POS_MAX);
  localparam logic [11:0] MIN_X = 12'(POS_MIN);
  localparam logic [11:0] L_X   = 12'(PADDLE_L_X);
  localparam logic [11:0] R_X   = 12'(PADDLE_R_X);
  localparam logic [3:0]  WIN_S = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, PLAY, LOCKOUT, GAME_OVER} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       score_l_q, score_r_q;
  logic [3:0]       score_l_d, score_r_d;
  logic             hit_q, win_q, game_over_q, winner_q;

  logic [11:0] ball_x;
  logic        ovl_l, ovl_r;
  logic        hit_l, hit_r, hit_any;
  logic        miss_l, miss_r;

  // Paddle span is widened to 12 bits so a paddle near the bottom edge cannot wrap to Y=0.
  function automatic logic overlap(input logic [10:0] paddle_y, input logic [10:0] ball_y);
    logic [11:0] top;
    logic [11:0] bot;
    top = {1'b0, paddle_y};
    bot = top + 12'(PADDLE_HEIGHT - 1);
    return ({1'b0, ball_y} >= top) && ({1'b0, ball_y} <= bot);
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s >= WIN_S) ? WIN_S : s + 4'd1;
  endfunction

  assign ball_x  = {1'b0, i_Ball_X};
  assign ovl_l   = overlap(i_Paddle_L_Y, i_Ball_Y);
  assign ovl_r   = overlap(i_Paddle_R_Y, i_Ball_Y);
  assign hit_r   = i_Direction  && (ball_x >= R_X) && ovl_r;
  assign hit_l   = !i_Direction && (ball_x <= L_X) && ovl_l;
  assign hit_any = hit_r || hit_l;
  // A hit always wins over a miss at the same position.
  assign miss_r  = i_Direction  && (ball_x > MAX_X) && !hit_r;
  assign miss_l  = !i_Direction && (ball_x < MIN_X) && !hit_l;

  assign score_l_d = score_inc(score_l_q);
  assign score_r_d = score_inc(score_r_q);

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      hit_q       <= 1'b0;
      win_q       <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      win_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_Space) state_q <= PLAY;
        end
        PLAY: begin
          if (hit_any) begin
            hit_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= LOCKOUT;
          end else if (miss_r) begin
            win_q     <= 1'b1;
            score_l_q <= score_l_d;
            if (score_l_d == WIN_S) begin
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
              winner_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else if (miss_l) begin
            win_q     <= 1'b1;
            score_r_q <= score_r_d;
            if (score_r_d == WIN_S) begin
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
              winner_q    <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        LOCKOUT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= PLAY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAME_OVER: begin
          if (i_Space) begin
            score_l_q   <= '0;
            score_r_q   <= '0;
            winner_q    <= 1'b0;
            game_over_q <= 1'b0;
            state_q     <= PLAY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Paddle_Hit = hit_q;
  assign o_Win        = win_q;
  assign o_Score_L    = score_l_q;
  assign o_Score_R    = score_r_q;
  assign o_Game_Over  = game_over_q;
  assign o_Winner     = winner_q;

endmodule
